// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Bursts are capped at MAX_BURST words and cut short by f_almost_full; f_full stalls the grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      f_full,
    input  logic                      f_almost_full,
    output logic                      enable_wr,
    output logic [DATA_W-1:0]         data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;

    logic [DATA_W-1:0]  req_word [NUM_REQ];
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   inc_idx;
    logic               pick_found;
    logic               cur_valid;
    logic               xfer;
    logic               last_word;
    logic               release_grant;
    int                 pick_pos;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Walk offsets high to low so the valid requester nearest rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_pos = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (req_valid[IDX_W'(pick_pos)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(pick_pos);
            end
        end
    end

    assign cur_valid = req_valid[gidx_reg];
    assign inc_idx   = (int'(gidx_reg) == NUM_REQ - 1) ? '0 : gidx_reg + 1'b1;
    assign xfer      = (state_reg == GRANT) && !f_full && cur_valid;
    assign last_word = (burst_cnt_reg == CNT_W'(MAX_BURST - 1));

    assign req_ready = ((state_reg == GRANT) && !f_full) ? grant_reg : '0;
    assign enable_wr = xfer;
    assign data_in   = xfer ? req_word[gidx_reg] : '0;
    assign grant     = grant_reg;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        gidx_next      = gidx_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        release_grant  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!f_full && pick_found) begin
                    state_next     = GRANT;
                    grant_next     = NUM_REQ'(1) << pick_idx;
                    gidx_next      = pick_idx;
                    burst_cnt_next = '0;
                end
            end
            GRANT: begin
                if (f_full) begin
                    state_next = STALL;
                end else if (!cur_valid) begin
                    release_grant = 1'b1;
                end else begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                    if (last_word || f_almost_full) begin
                        release_grant = 1'b1;
                    end
                end
            end
            STALL: begin
                if (!cur_valid) begin
                    release_grant = 1'b1;
                end else if (!f_full) begin
                    state_next = GRANT;
                end
            end
            default: state_next = IDLE;
        endcase
        // A released grant hands priority to the next requester up.
        if (release_grant) begin
            state_next     = IDLE;
            grant_next     = '0;
            rr_ptr_next    = inc_idx;
            burst_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            gidx_reg      <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            gidx_reg      <= gidx_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vectors with hand-computed outputs.
// Requester k presents word {k, n} where n counts words it has had accepted.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      f_full;
    logic                      f_almost_full;
    logic                      enable_wr;
    logic [DATA_W-1:0]         data_in;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .f_full       (f_full),
        .f_almost_full(f_almost_full),
        .enable_wr    (enable_wr),
        .data_in      (data_in),
        .grant        (grant),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       full;
        logic       afull;
        logic [3:0] e_grant;
        logic [3:0] e_ready;
        logic       e_wr;
        logic [7:0] e_data;
        logic       e_busy;
        logic       chk_comb;
    } vec_t;

    vec_t tbl[$];
    int   wcnt [NUM_REQ];
    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;

    function automatic vec_t mk(logic rst_n, logic [3:0] valid, logic full, logic afull,
                                logic [3:0] e_grant, logic [3:0] e_ready, logic e_wr,
                                logic [7:0] e_data, logic e_busy, logic chk_comb);
        vec_t v;
        v.rst_n    = rst_n;
        v.valid    = valid;
        v.full     = full;
        v.afull    = afull;
        v.e_grant  = e_grant;
        v.e_ready  = e_ready;
        v.e_wr     = e_wr;
        v.e_data   = e_data;
        v.e_busy   = e_busy;
        v.chk_comb = chk_comb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h want %h", vec_no, name, act, exp);
        end
    endtask

    // One clock: drive at negedge, compare shortly after, then account accepted words.
    task automatic cycle(input vec_t v);
        @(negedge clk);
        reset_n       = v.rst_n;
        req_valid     = v.valid;
        f_full        = v.full;
        f_almost_full = v.afull;
        for (int k = 0; k < NUM_REQ; k++)
            req_data[k*DATA_W +: DATA_W] = {4'(k), 4'(wcnt[k])};
        #1;
        chk("grant", 8'(grant), 8'(v.e_grant));
        chk("busy", 8'(busy), 8'(v.e_busy));
        if (v.chk_comb) begin
            chk("req_ready", 8'(req_ready), 8'(v.e_ready));
            chk("enable_wr", 8'(enable_wr), 8'(v.e_wr));
            chk("data_in", data_in, v.e_data);
        end
        $display("vec %0d: rst_n=%b valid=%b full=%b afull=%b -> grant=%b ready=%b wr=%b data=%h busy=%b",
                 vec_no, v.rst_n, v.valid, v.full, v.afull, grant, req_ready, enable_wr, data_in, busy);
        for (int k = 0; k < NUM_REQ; k++)
            if (req_valid[k] && req_ready[k]) wcnt[k]++;
        vec_no++;
    endtask

    task automatic clear_words();
        for (int k = 0; k < NUM_REQ; k++) wcnt[k] = 0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset_n       = 1'b0;
        req_valid     = 4'hF;
        req_data      = '0;
        f_full        = 1'b0;
        f_almost_full = 1'b0;
        clear_words();

        // Reset with everyone requesting, then req 1 alone for 6 words, then almost-full cut.
        tbl.push_back(mk(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h10, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h11, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h12, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h13, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h14, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 4'b0010, 4'b0010, 1, 8'h15, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0010, 4'b0010, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 1, 4'b0100, 4'b0100, 1, 8'h20, 1, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b1100, 0, 0, 4'b1000, 4'b1000, 1, 8'h30, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b1000, 4'b1000, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));

        foreach (tbl[i]) cycle(tbl[i]);

        // All four requesting continuously: rotation 0,1,2,3,0 with full bursts.
        clear_words();
        for (int r = 0; r < 5; r++) begin
            cycle(mk(1, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
            for (int k = 0; k < MAX_BURST; k++)
                cycle(mk(1, 4'b1111, 0, 0, 4'(1 << order[r]), 4'(1 << order[r]), 1,
                         {4'(order[r]), 4'((r == 4 ? 4 : 0) + k)}, 1, 1));
        end
        cycle(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));

        // FIFO fills after two words of req 0; burst resumes with the remaining two.
        clear_words();
        cycle(mk(1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        cycle(mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0001, 1, 8'h00, 1, 1));
        cycle(mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0001, 1, 8'h01, 1, 1));
        for (int s = 0; s < 3; s++)
            cycle(mk(1, 4'b0001, 1, 0, 4'b0001, 4'b0000, 0, 8'h00, 1, 1));
        cycle(mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 8'h00, 1, 1));
        cycle(mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0001, 1, 8'h02, 1, 1));
        cycle(mk(1, 4'b0001, 0, 0, 4'b0001, 4'b0001, 1, 8'h03, 1, 1));
        cycle(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));

        // Reset on the third clock of a req 2 burst; pointer returns to 0.
        clear_words();
        cycle(mk(1, 4'b0100, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        cycle(mk(1, 4'b0100, 0, 0, 4'b0100, 4'b0100, 1, 8'h20, 1, 1));
        cycle(mk(1, 4'b0100, 0, 0, 4'b0100, 4'b0100, 1, 8'h21, 1, 1));
        cycle(mk(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 0, 8'h00, 1, 0));
        cycle(mk(1, 4'b0101, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));
        cycle(mk(1, 4'b0101, 0, 0, 4'b0001, 4'b0001, 1, 8'h00, 1, 1));
        cycle(mk(1, 4'b0000, 0, 0, 4'b0001, 4'b0001, 0, 8'h00, 1, 1));
        cycle(mk(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 8'h00, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
